// File: rtl/tank_render_multi.sv
// Multi-tank pixel renderer: draws up to N_TANKS tanks (or their explosions)
// on a cell grid and produces one 12-bit RGB colour per VGA pixel.
// Tank attributes are frozen per frame; lower channel index wins on overlap.
// Latency from pixel coordinates to VGA_data/VGA_en is two clock cycles.
module tank_render_multi #(
  parameter int          N_TANKS     = 4,
  parameter int          POS_W       = 5,
  parameter int          CELL        = 20,
  parameter int          X_ORG       = 160,
  parameter int          Y_ORG       = 40,
  parameter int          BODY_R      = 7,
  parameter int          BARREL_R    = 3,
  parameter int          EXPL_FRAMES = 3,
  parameter logic [11:0] MY_COLOR    = 12'h00F,
  parameter logic [11:0] EN_COLOR    = 12'hF00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [10:0]                VGA_xpos,
  input  logic [10:0]                VGA_ypos,
  input  logic [N_TANKS*POS_W-1:0]   tank_x_pos,
  input  logic [N_TANKS*POS_W-1:0]   tank_y_pos,
  input  logic [N_TANKS*2-1:0]       tank_dir,
  input  logic [N_TANKS-1:0]         tank_state,
  input  logic [N_TANKS-1:0]         tank_ide,
  output logic [11:0]                VGA_data,
  output logic                       VGA_en
);

  localparam int                CNT_W      = $clog2(EXPL_FRAMES + 1);
  localparam logic [CNT_W-1:0]  EXPL_LOAD  = CNT_W'(EXPL_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic signed [12:0] BODY_LIM   = 13'(BODY_R);
  localparam logic signed [12:0] BARREL_LIM = 13'(BARREL_R);
  localparam logic signed [12:0] ZERO       = '0;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Per-frame snapshot of every channel
  logic [POS_W-1:0]   snap_x   [N_TANKS];
  logic [POS_W-1:0]   snap_y   [N_TANKS];
  dir_e               snap_dir [N_TANKS];
  logic [N_TANKS-1:0] snap_state;
  logic [N_TANKS-1:0] snap_ide;
  logic [CNT_W-1:0]   expl_cnt [N_TANKS];

  // Geometry and per-channel hit evaluation
  logic [11:0]        cx [N_TANKS];
  logic [11:0]        cy [N_TANKS];
  logic signed [12:0] dx [N_TANKS];
  logic signed [12:0] dy [N_TANKS];
  logic [N_TANKS-1:0] shape_c;
  logic [N_TANKS-1:0] box_c;
  logic [N_TANKS-1:0] hit_c;
  logic [11:0]        color_c [N_TANKS];

  // Stage 1 registers and stage 2 priority result
  logic [N_TANKS-1:0] s1_hit;
  logic [11:0]        s1_color [N_TANKS];
  logic [11:0]        data_c;
  logic               en_c;

  // Open interval test lo < v < hi on signed pixel offsets.
  function automatic logic inside_open(input logic signed [12:0] v,
                                       input logic signed [12:0] lo,
                                       input logic signed [12:0] hi);
    return (v > lo) && (v < hi);
  endfunction

  // Capture tank attributes and advance explosion counters once per frame.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the counter update below relies on reading the old snap_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_state <= '0;
      snap_ide   <= '0;
      // NOTE: these small register arrays are reset element by element so no
      // stale tank or explosion can appear in the first frame after reset.
      for (int i = 0; i < N_TANKS; i++) begin
        snap_x[i]   <= '0;
        snap_y[i]   <= '0;
        snap_dir[i] <= DIR_UP;
        expl_cnt[i] <= '0;
      end
    end else if (frame_start) begin
      snap_state <= tank_state;
      snap_ide   <= tank_ide;
      for (int i = 0; i < N_TANKS; i++) begin
        snap_x[i]   <= tank_x_pos[i*POS_W +: POS_W];
        snap_y[i]   <= tank_y_pos[i*POS_W +: POS_W];
        snap_dir[i] <= dir_e'(tank_dir[i*2 +: 2]);
        if (snap_state[i] && !tank_state[i])
          expl_cnt[i] <= EXPL_LOAD;
        else if (tank_state[i])
          expl_cnt[i] <= '0;
        else if (expl_cnt[i] != '0)
          expl_cnt[i] <= expl_cnt[i] - CNT_ONE;
      end
    end
  end

  // Per-channel shape test against the current pixel and colour selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held over and infer a latch.
    shape_c = '0;
    box_c   = '0;
    hit_c   = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      color_c[i] = '0;
      cx[i] = 12'(snap_x[i] * CELL + X_ORG);
      cy[i] = 12'(snap_y[i] * CELL + Y_ORG);
      dx[i] = $signed({2'b00, VGA_xpos}) - $signed({1'b0, cx[i]});
      dy[i] = $signed({2'b00, VGA_ypos}) - $signed({1'b0, cy[i]});
      case (snap_dir[i])
        DIR_UP:    shape_c[i] = (inside_open(dx[i], -BARREL_LIM, BARREL_LIM) && inside_open(dy[i], -BODY_LIM, ZERO))
                             || (inside_open(dx[i], -BODY_LIM, BODY_LIM)     && inside_open(dy[i], ZERO, BODY_LIM));
        DIR_DOWN:  shape_c[i] = (inside_open(dx[i], -BODY_LIM, BODY_LIM)     && inside_open(dy[i], -BODY_LIM, ZERO))
                             || (inside_open(dx[i], -BARREL_LIM, BARREL_LIM) && inside_open(dy[i], ZERO, BODY_LIM));
        DIR_LEFT:  shape_c[i] = (inside_open(dx[i], -BODY_LIM, ZERO) && inside_open(dy[i], -BARREL_LIM, BARREL_LIM))
                             || (inside_open(dx[i], ZERO, BODY_LIM)  && inside_open(dy[i], -BODY_LIM, BODY_LIM));
        DIR_RIGHT: shape_c[i] = (inside_open(dx[i], -BODY_LIM, ZERO) && inside_open(dy[i], -BODY_LIM, BODY_LIM))
                             || (inside_open(dx[i], ZERO, BODY_LIM)  && inside_open(dy[i], -BARREL_LIM, BARREL_LIM));
        default:   shape_c[i] = 1'b0;
      endcase
      box_c[i] = inside_open(dx[i], -BODY_LIM, BODY_LIM) && inside_open(dy[i], -BODY_LIM, BODY_LIM);
      hit_c[i] = (snap_state[i] && shape_c[i]) || ((expl_cnt[i] != '0) && box_c[i]);
      if (snap_state[i] && shape_c[i])
        color_c[i] = snap_ide[i] ? MY_COLOR : EN_COLOR;
      else
        color_c[i] = expl_cnt[i][0] ? 12'hFF0 : 12'hFFF;
    end
  end

  // Stage 1: register per-channel hit flags and colours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit <= '0;
      for (int i = 0; i < N_TANKS; i++) s1_color[i] <= '0;
    end else begin
      s1_hit <= hit_c;
      for (int i = 0; i < N_TANKS; i++) s1_color[i] <= color_c[i];
    end
  end

  // Fixed priority: scanning downwards leaves the lowest hit channel on top.
  always_comb begin
    data_c = '0;
    en_c   = 1'b0;
    for (int i = N_TANKS - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        en_c   = 1'b1;
        data_c = s1_color[i];
      end
    end
  end

  // Stage 2: register the layer output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VGA_data <= '0;
      VGA_en   <= 1'b0;
    end else begin
      VGA_data <= data_c;
      VGA_en   <= en_c;
    end
  end

endmodule

// File: doc/tank_render_multi.md
Name: tank_render_multi

Overview:
- Parametrised successor to the single-tank pixel renderer.
- Draws up to N_TANKS tanks on a cell grid and picks one pixel colour per VGA pixel. Lower channel index wins when tanks overlap.
- Tank attributes are captured once per frame, on frame_start, so a tank cannot tear mid-frame.
- When a tank dies, a flashing explosion square is drawn at its cell for EXPL_FRAMES frames.
- Output feeds the VGA colour mux alongside the map and bullet layers.

Parameters:
- N_TANKS, 4: number of tank channels.
- POS_W, 5: width of each tank's cell x/y coordinate.
- CELL, 20: cell pitch in pixels.
- X_ORG, 160: pixel x of the centre of cell column 0.
- Y_ORG, 40: pixel y of the centre of cell row 0.
- BODY_R, 7: body half-extent; the bound is exclusive.
- BARREL_R, 3: barrel half-width; the bound is exclusive.
- EXPL_FRAMES, 3: number of frames the explosion is shown.
- MY_COLOR, 12'h00F: colour of a tank with ide=1.
- EN_COLOR, 12'hF00: colour of a tank with ide=0.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- frame_start  in  1  one-cycle pulse before each frame's first pixel.
- VGA_xpos  in  11  current pixel x.
- VGA_ypos  in  11  current pixel y.
- tank_x_pos  in  N_TANKS*POS_W  cell x per tank; channel i occupies slice [i*POS_W +: POS_W].
- tank_y_pos  in  N_TANKS*POS_W  cell y per tank.
- tank_dir  in  N_TANKS*2  direction per tank: 00 up, 01 down, 10 left, 11 right.
- tank_state  in  N_TANKS  1 = alive.
- tank_ide  in  N_TANKS  1 = player tank, 0 = enemy tank.
- VGA_data  out  12  RGB 4|4|4.
- VGA_en  out  1  pixel belongs to this layer.

Behaviour:
- Reset (clk is the only clock; rst is asynchronous, active-high). Clears immediately:
  - VGA_data=0 and VGA_en=0.
  - All snapshot registers (state, ide, dir, positions) and all pipeline registers.
  - All explosion counters.
  - Effect: nothing is drawn until the first frame_start after reset.
- Snapshot:
  - On a cycle with frame_start=1, every channel's x, y, dir, state and ide are registered.
  - Between pulses, input changes have no effect.
- Explosion counter (per channel, width clog2(EXPL_FRAMES+1)), updated on frame_start:
  - Snapshot state 1 and new state 0: load EXPL_FRAMES.
  - New state 1: clear the counter.
  - Otherwise, if nonzero: decrement.
- Geometry:
  - Centre: cx = x*CELL + X_ORG and cy = y*CELL + Y_ORG, computed in 12-bit unsigned.
  - dx = xpos-cx and dy = ypos-cy, 13-bit signed.
  - Row dy=0 (up/down) and column dx=0 (left/right) are never drawn.
- Shape by direction:
  - Up: barrel |dx|<BARREL_R with -BODY_R<dy<0; body |dx|<BODY_R with 0<dy<BODY_R.
  - Down: body |dx|<BODY_R with -BODY_R<dy<0; barrel |dx|<BARREL_R with 0<dy<BODY_R.
  - Left: barrel -BODY_R<dx<0 with |dy|<BARREL_R; body 0<dx<BODY_R with |dy|<BODY_R.
  - Right: body -BODY_R<dx<0 with |dy|<BODY_R; barrel 0<dx<BODY_R with |dy|<BARREL_R.
- Hit and colour per channel:
  - Tank hit: snapshot state=1 and the pixel is inside the shape. Colour = MY_COLOR if ide=1, else EN_COLOR.
  - Explosion hit: counter≠0 and |dx|<BODY_R and |dy|<BODY_R. Colour = 12'hFF0 if the counter is odd, 12'hFFF if even.
- Pipeline: fixed latency of 2 cycles from pixel inputs to outputs.
  - Stage 1 registers per-channel hit flags and colours.
  - Stage 2 applies the fixed priority (lowest-index channel with any hit wins) and registers VGA_data/VGA_en.
  - No hit: VGA_data=0 and VGA_en=0.
- frame_start coincident with a pixel: that pixel uses the pre-update snapshot. Pixels already in the pipeline are unaffected.
- Cell positions whose centre lands off-screen are allowed; the result is simply clipped.

Test Plan:
Default parameters; results are checked 2 cycles after pixel input.
1. Tank0 at (2,3), up, ide=1, frame_start (centre 200,100):
   - Pixel (200,95) -> VGA_data 0x00F, en=1.
   - Pixel (196,95) -> en=0 (outside barrel).
   - Pixel (194,103) -> en=1 (body).
   - Pixel (200,100) -> en=0 (gap row).
2. Tank0 at (0,0), right, ide=0 (centre 160,40):
   - Pixel (165,40) -> 0xF00, en=1 (barrel).
   - Pixel (155,46) -> en=1 (body).
   - Pixel (160,40) -> en=0 (gap column).
   - Pixel (165,43) -> en=0 (outside barrel).
3. Overlap: tank0 (ide=1) and tank1 (ide=0) both at (2,3) up; pixel (200,103) -> 0x00F (channel 0 wins).
4. Snapshot: after frame_start, move tank0 to (5,5) with no pulse; pixel (200,103) -> still en=1. After the next frame_start -> en=0.
5. Explosion: tank2 alive at (2,3), then state 0 at a frame_start. Pixel (206,94) over the next 3 frames gives FF0, FFF, FF0; 4th frame -> en=0. Reasserting state mid-explosion clears the counter at the next frame_start.
6. Assert rst mid-frame with tanks drawn -> VGA_en=0 and VGA_data=0 immediately. Nothing drawn until after the first frame_start following reset release.
